// File: rtl/bp_table_arbiter.sv
// Branch-predictor table port arbiter: shares one single-ported RAM between fetch lookups
// and queued read-modify-write counter training, after a post-reset init sweep.
module bp_table_arbiter #(
    parameter int unsigned IDX_W      = 10,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned STARVE_MAX = 8,
    parameter logic [1:0]  INIT_CTR   = 2'b01
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lookup_req,
    input  logic [IDX_W-1:0] lookup_idx,
    output logic             lookup_stall,
    output logic             lookup_valid,
    output logic             pred_taken,
    output logic [15:0]      pred_target,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    input  logic [15:0]      upd_target,
    output logic             upd_ready,
    output logic             init_busy,
    output logic             ram_en,
    output logic             ram_we,
    output logic             ram_we_tgt,
    output logic [IDX_W-1:0] ram_addr,
    output logic [1:0]       ram_wdata_ctr,
    output logic [15:0]      ram_wdata_tgt,
    input  logic [1:0]       ram_rdata_ctr,
    input  logic [15:0]      ram_rdata_tgt
);

    localparam int unsigned TGT_W = 16;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_UPD_WR} state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             taken;
        logic [TGT_W-1:0] target;
    } upd_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  init_addr;
    upd_t              fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [STV_W-1:0]  starve_cnt;
    upd_t              head;
    logic              empty, full, push, pop, lookup_grant;
    logic [1:0]        new_ctr;

    logic              ram_en_c, ram_we_c, ram_we_tgt_c;
    logic [IDX_W-1:0]  ram_addr_c;
    logic [1:0]        ram_wdata_ctr_c;
    logic [TGT_W-1:0]  ram_wdata_tgt_c;

    assign head      = fifo_q[rd_ptr];
    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign upd_ready = !full && (state_q != ST_INIT);
    assign push      = upd_valid && upd_ready;
    assign init_busy = (state_q == ST_INIT);

    // Saturating 2-bit counter training
    always_comb begin
        new_ctr = ram_rdata_ctr;
        if (head.taken) begin
            if (ram_rdata_ctr != 2'b11) new_ctr = ram_rdata_ctr + 2'd1;
        end else begin
            if (ram_rdata_ctr != 2'b00) new_ctr = ram_rdata_ctr - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_INIT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        ram_en_c        = 1'b0;
        ram_we_c        = 1'b0;
        ram_we_tgt_c    = 1'b0;
        ram_addr_c      = '0;
        ram_wdata_ctr_c = 2'b00;
        ram_wdata_tgt_c = '0;
        lookup_stall    = lookup_req;
        lookup_grant    = 1'b0;
        pop             = 1'b0;
        case (state_q)
            ST_INIT: begin
                ram_en_c        = 1'b1;
                ram_we_c        = 1'b1;
                ram_we_tgt_c    = 1'b1;
                ram_addr_c      = init_addr;
                ram_wdata_ctr_c = INIT_CTR;
                if (init_addr == LAST_IDX) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (!empty && (full || starve_cnt == STV_W'(STARVE_MAX) || !lookup_req)) begin
                    ram_en_c   = 1'b1;
                    ram_addr_c = head.idx;
                    state_d    = ST_UPD_WR;
                end else if (lookup_req) begin
                    ram_en_c     = 1'b1;
                    ram_addr_c   = lookup_idx;
                    lookup_stall = 1'b0;
                    lookup_grant = 1'b1;
                end
            end
            ST_UPD_WR: begin
                ram_en_c        = 1'b1;
                ram_we_c        = 1'b1;
                ram_we_tgt_c    = head.taken;
                ram_addr_c      = head.idx;
                ram_wdata_ctr_c = new_ctr;
                ram_wdata_tgt_c = head.target;
                pop             = 1'b1;
                state_d         = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // RAM strobes are held quiet while reset is asserted
    assign ram_en        = ram_en_c && !reset;
    assign ram_we        = ram_we_c && !reset;
    assign ram_we_tgt    = ram_we_tgt_c && !reset;
    assign ram_addr      = reset ? '0 : ram_addr_c;
    assign ram_wdata_ctr = reset ? 2'b00 : ram_wdata_ctr_c;
    assign ram_wdata_tgt = reset ? '0 : ram_wdata_tgt_c;

    assign pred_taken  = lookup_valid && ram_rdata_ctr[1];
    assign pred_target = lookup_valid ? ram_rdata_tgt : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_addr    <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            starve_cnt   <= '0;
            lookup_valid <= 1'b0;
        end else begin
            lookup_valid <= lookup_grant;
            if (state_q == ST_INIT) init_addr <= init_addr + IDX_W'(1);
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (pop) begin
                starve_cnt <= '0;
            end else if (lookup_grant) begin
                if (empty)                                starve_cnt <= '0;
                else if (starve_cnt != STV_W'(STARVE_MAX)) starve_cnt <= starve_cnt + STV_W'(1);
            end
        end
    end

    // Queue storage needs no reset; occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr] <= {upd_idx, upd_taken, upd_target};
    end

endmodule

// File: tb/tb_bp_table_arbiter.sv
// Directed bench for bp_table_arbiter; RAM read data is driven directly by the bench.
module tb_bp_table_arbiter;

    logic        clk, reset;
    logic        lookup_req;
    logic [9:0]  lookup_idx;
    logic        lookup_stall, lookup_valid, pred_taken;
    logic [15:0] pred_target;
    logic        upd_valid, upd_taken, upd_ready, init_busy;
    logic [9:0]  upd_idx;
    logic [15:0] upd_target;
    logic        ram_en, ram_we, ram_we_tgt;
    logic [9:0]  ram_addr;
    logic [1:0]  ram_wdata_ctr, ram_rdata_ctr;
    logic [15:0] ram_wdata_tgt, ram_rdata_tgt;

    int n_vec = 0;
    int n_err = 0;

    bp_table_arbiter dut (
        .clk(clk), .reset(reset),
        .lookup_req(lookup_req), .lookup_idx(lookup_idx),
        .lookup_stall(lookup_stall), .lookup_valid(lookup_valid),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_ready(upd_ready), .init_busy(init_busy),
        .ram_en(ram_en), .ram_we(ram_we), .ram_we_tgt(ram_we_tgt),
        .ram_addr(ram_addr), .ram_wdata_ctr(ram_wdata_ctr), .ram_wdata_tgt(ram_wdata_tgt),
        .ram_rdata_ctr(ram_rdata_ctr), .ram_rdata_tgt(ram_rdata_tgt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Training vectors: taken, counter read back, expected counter written
    logic       sat_tk  [6];
    logic [1:0] sat_rd  [6];
    logic [1:0] sat_exp [6];

    initial begin
        sat_tk  = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
        sat_rd  = '{2'b11, 2'b00, 2'b01, 2'b10, 2'b00, 2'b11};
        sat_exp = '{2'b11, 2'b00, 2'b10, 2'b01, 2'b01, 2'b10};

        reset = 1'b1; lookup_req = 1'b1; lookup_idx = '0;
        upd_valid = 1'b1; upd_idx = 10'h3FF; upd_taken = 1'b1; upd_target = 16'hFFFF;
        ram_rdata_ctr = 2'b00; ram_rdata_tgt = 16'h0;
        tick(); tick();
        check("rst_state", {63'(0), init_busy, upd_ready, ram_en, ram_we, lookup_valid},
              {63'(0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

        // Init sweep: one write per cycle over every index
        reset = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            #1;
            check("init_sweep",
                  {ram_en, ram_we, ram_we_tgt, ram_wdata_ctr, ram_wdata_tgt,
                   upd_ready, init_busy, lookup_stall, ram_addr},
                  {3'b111, 2'b01, 16'h0, 1'b0, 1'b1, 1'b1, 10'(i)});
            tick();
        end
        lookup_req = 1'b0; upd_valid = 1'b0;
        #1 check("init_done", {init_busy, upd_ready, ram_en, lookup_stall}, {1'b0, 1'b1, 1'b0, 1'b0});

        // Lookup path
        tick();
        lookup_req = 1'b1; lookup_idx = 10'h2A5;
        #1 check("lkp_grant", {lookup_stall, ram_en, ram_we, ram_addr}, {1'b0, 1'b1, 1'b0, 10'h2A5});
        ram_rdata_ctr = 2'b10; ram_rdata_tgt = 16'h3000;
        tick();
        lookup_req = 1'b0;
        #1 check("lkp_result", {lookup_valid, pred_taken, pred_target}, {1'b1, 1'b1, 16'h3000});
        tick();
        #1 check("lkp_pulse", {lookup_valid, pred_taken, pred_target}, {1'b0, 1'b0, 16'h0});

        // Counter training including both saturation limits
        for (int k = 0; k < 6; k++) begin
            upd_valid = 1'b1; upd_idx = 10'(5 + k * 37); upd_taken = sat_tk[k];
            upd_target = 16'h1234 + 16'(k); lookup_req = 1'b0;
            #1 check("upd_ready", {63'(0), upd_ready}, 64'd1);
            tick();
            upd_valid = 1'b0;
            #1 check("upd_read", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, 10'(5 + k * 37)});
            ram_rdata_ctr = sat_rd[k];
            tick();
            #1 check("upd_write", {ram_en, ram_we, ram_we_tgt, ram_wdata_ctr, ram_wdata_tgt, ram_addr},
                     {1'b1, 1'b1, sat_tk[k], sat_exp[k], 16'h1234 + 16'(k), 10'(5 + k * 37)});
            tick();
        end

        // Starvation: 8 lookups granted while an update waits, then a 2-cycle RMW
        lookup_req = 1'b1; lookup_idx = 10'h010;
        upd_valid = 1'b1; upd_idx = 10'h009; upd_taken = 1'b1; upd_target = 16'h4444;
        #1 check("stv_push_cycle", {lookup_stall, ram_addr}, {1'b0, 10'h010});
        tick();
        upd_valid = 1'b0;
        for (int g = 0; g < 8; g++) begin
            #1 check("stv_grant", {lookup_stall, ram_en, ram_we, ram_addr}, {1'b0, 1'b1, 1'b0, 10'h010});
            tick();
        end
        #1 check("stv_read", {lookup_stall, ram_en, ram_we, ram_addr}, {1'b1, 1'b1, 1'b0, 10'h009});
        ram_rdata_ctr = 2'b01;
        tick();
        #1 check("stv_write", {lookup_stall, ram_we, ram_wdata_ctr, ram_addr}, {1'b1, 1'b1, 2'b10, 10'h009});
        tick();
        #1 check("stv_resume", {lookup_stall, ram_we, ram_addr}, {1'b0, 1'b0, 10'h010});
        tick();

        // Full queue forces the update ahead of the starvation limit
        lookup_idx = 10'h020;
        for (int j = 0; j < 4; j++) begin
            upd_valid = 1'b1; upd_idx = 10'h100 + 10'(j); upd_taken = j[0];
            upd_target = 16'hA000 + 16'(j);
            #1 check("fq_fill", {upd_ready, lookup_stall}, {1'b1, 1'b0});
            tick();
        end
        upd_idx = 10'h155; upd_taken = 1'b1; upd_target = 16'hBBBB;
        #1 check("fq_full_read", {upd_ready, lookup_stall, ram_en, ram_we, ram_addr},
                 {1'b0, 1'b1, 1'b1, 1'b0, 10'h100});
        ram_rdata_ctr = 2'b01;
        tick();
        #1 check("fq_full_write", {upd_ready, lookup_stall, ram_we, ram_we_tgt, ram_wdata_ctr, ram_addr},
                 {1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 10'h100});
        tick();
        #1 check("fq_ready_back", {upd_ready, lookup_stall, ram_en, ram_we, ram_addr},
                 {1'b1, 1'b0, 1'b1, 1'b0, 10'h020});
        tick();
        upd_valid = 1'b0; lookup_req = 1'b0;
        #1 check("fq_refull_read", {upd_ready, ram_en, ram_we, ram_addr}, {1'b0, 1'b1, 1'b0, 10'h101});
        tick();
        #1 check("rmw_write", {ram_we, ram_addr}, {1'b1, 10'h101});

        // Asynchronous reset in the middle of the write cycle
        reset = 1'b1;
        #1 check("rst_mid_rmw", {ram_en, ram_we, ram_we_tgt, ram_addr, init_busy, upd_ready},
                 {1'b0, 1'b0, 1'b0, 10'h0, 1'b1, 1'b0});
        tick();
        reset = 1'b0;
        #1 check("reinit_start", {ram_en, ram_we, ram_addr, init_busy, upd_ready},
                 {1'b1, 1'b1, 10'h0, 1'b1, 1'b0});
        for (int i = 0; i < 1024; i++) tick();
        #1 check("reinit_done", {init_busy, upd_ready, ram_en}, {1'b0, 1'b1, 1'b0});
        tick();
        #1 check("queue_flushed", {ram_en, ram_we, init_busy}, {1'b0, 1'b0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
